// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C master engine among NUM_REQ requesters.
// It latches the winner's command, launches the master and waits for the
// master's done edge. The result goes back to the winner as a one-cycle
// response. A watchdog pulses the master's reset when a transfer hangs.
module i2c_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int NEWD_HOLD   = 24,
  parameter int TIMEOUT_CYC = 65535,
  parameter int ABORT_CYC   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_wr,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic                   rsp_err,
  output logic [7:0]             rsp_rdata,
  output logic                   busy,
  output logic                   m_newd,
  output logic                   m_wr,
  output logic [6:0]             m_addr,
  output logic [7:0]             m_wdata,
  input  logic [7:0]             m_rdata,
  input  logic                   m_done,
  output logic                   m_abort
);

  localparam int PW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CMAX_A = (TIMEOUT_CYC > ABORT_CYC) ? TIMEOUT_CYC : ABORT_CYC;
  localparam int CMAX   = (CMAX_A > NEWD_HOLD) ? CMAX_A : NEWD_HOLD;
  localparam int CW     = $clog2(CMAX + 1);

  localparam logic [CW-1:0] HOLD_LAST  = CW'(NEWD_HOLD - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] ABORT_LAST = CW'(ABORT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  // One counter serves both phases: it runs from ISSUE entry through WAIT
  // (newd hold and watchdog share it), then restarts for the abort pulse.
  logic [CW-1:0]   cnt;
  logic            done_q;
  logic            done_cap;
  logic            done_rise;
  logic            pick_vld;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   scan_idx;

  assign done_rise = m_done & ~done_q;
  assign busy      = (state != S_IDLE);

  // Round-robin scan: first active request at or after rr_ptr, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!pick_vld && req[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  // Transfer sequencer: grant, master launch, done wait, watchdog abort, response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      done_q    <= 1'b0;
      done_cap  <= 1'b0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      m_newd    <= 1'b0;
      m_wr      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_abort   <= 1'b0;
    end else begin
      done_q    <= m_done;
      rsp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            gnt      <= NUM_REQ'(1) << pick_idx;
            m_wr     <= req_wr[pick_idx];
            m_addr   <= req_addr[7*int'(pick_idx) +: 7];
            m_wdata  <= req_wdata[8*int'(pick_idx) +: 8];
            rr_ptr   <= PW'((int'(pick_idx) + 1) % NUM_REQ);
            cnt      <= '0;
            done_cap <= 1'b0;
            m_newd   <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt <= cnt + 1'b1;
          // The master may finish while newd is still held; remember it for WAIT.
          if (done_rise) done_cap <= 1'b1;
          if (!(done_rise || done_cap) && cnt == TO_LAST) begin
            m_newd  <= 1'b0;
            m_abort <= 1'b1;
            cnt     <= '0;
            state   <= S_ABORT;
          end else if (cnt == HOLD_LAST) begin
            m_newd <= 1'b0;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (done_rise || done_cap) begin
            rsp_valid <= gnt;
            rsp_err   <= 1'b0;
            rsp_rdata <= m_wr ? 8'h00 : m_rdata;
            state     <= S_RESP;
          end else if (cnt == TO_LAST) begin
            m_abort <= 1'b1;
            cnt     <= '0;
            state   <= S_ABORT;
          end
        end
        S_ABORT: begin
          cnt <= cnt + 1'b1;
          if (cnt == ABORT_LAST) begin
            m_abort   <= 1'b0;
            rsp_valid <= gnt;
            rsp_err   <= 1'b1;
            rsp_rdata <= 8'h00;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          gnt       <= '0;
          rsp_err   <= 1'b0;
          rsp_rdata <= 8'h00;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: table of single transfers, fairness, reset
// mid-transfer and randomized traffic against a reference model.
module tb_i2c_req_arbiter;

  localparam int NR = 4;
  localparam int NH = 24;
  localparam int TO = 100;
  localparam int AB = 32;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req, req_wr;
  logic [7*NR-1:0] req_addr;
  logic [8*NR-1:0] req_wdata;
  logic [NR-1:0]   gnt, rsp_valid;
  logic            rsp_err;
  logic [7:0]      rsp_rdata;
  logic            busy, m_newd, m_wr, m_done, m_abort;
  logic [6:0]      m_addr;
  logic [7:0]      m_wdata, m_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  // master-model controls
  int         done_delay;
  logic [7:0] slave_rdata;

  bit         p_wr[NR];
  bit [6:0]   p_addr[NR];
  bit [7:0]   p_wdata[NR];

  typedef struct {
    int       who;
    bit       wr;
    bit [6:0] addr;
    bit [7:0] wdata;
    bit [7:0] sdata;
    int       d;
    bit       exp_err;
    bit [7:0] exp_rdata;
    int       exp_t;
  } vec_t;

  vec_t vt[8];
  int   order[5] = '{0, 1, 2, 3, 0};

  i2c_req_arbiter #(
    .NUM_REQ(NR), .NEWD_HOLD(NH), .TIMEOUT_CYC(TO), .ABORT_CYC(AB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .busy(busy), .m_newd(m_newd), .m_wr(m_wr), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_done(m_done), .m_abort(m_abort)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Behavioural I2C master: raises done (a level) done_delay cycles after
  // newd rises; abort or reset kill the pending completion.
  initial begin
    int mcnt;
    bit armed;
    bit prev_newd;
    m_done = 1'b0; m_rdata = 8'h00; mcnt = 0; armed = 1'b0; prev_newd = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n || m_abort) begin
        m_done = 1'b0; armed = 1'b0;
      end else if (m_newd && !prev_newd) begin
        m_done = 1'b0; armed = 1'b1; mcnt = 0;
      end
      if (armed) begin
        if (done_delay >= 0 && mcnt == done_delay) begin
          m_done = 1'b1; m_rdata = slave_rdata; armed = 1'b0;
        end
        mcnt++;
      end
      prev_newd = m_newd;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected outcome of one transfer from the response rules alone.
  task automatic ref_outcome(input int d, input bit wr, input bit [7:0] sdata,
                             output bit err, output bit [7:0] rd, output int t);
    err = (d < 0) || (d >= TO);
    rd  = (err || wr) ? 8'h00 : sdata;
    t   = err ? (TO + AB) : (((d < NH) ? NH : d) + 1);
  endtask

  function automatic int rr_next(input bit [NR-1:0] pend, input int last);
    for (int k = 1; k <= NR; k++)
      if (pend[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  task automatic set_req(input int i, input bit wr, input bit [6:0] a, input bit [7:0] wd);
    p_wr[i] = wr; p_addr[i] = a; p_wdata[i] = wd;
    req_wr[i] = wr;
    req_addr[i*7 +: 7] = a;
    req_wdata[i*8 +: 8] = wd;
    req[i] = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Called #1 after an edge with the DUT idle and the request(s) already set.
  task automatic run_xfer(input int who, input int d, input bit [7:0] sdata,
                          input bit exp_err, input bit [7:0] exp_rdata, input int exp_t,
                          input bit drop, input string nm);
    int t, newd_n, ab_n, ab_first, bad_gnt, rsp_t;
    bit got;
    logic [NR-1:0] rv;
    logic e;
    logic [7:0] rd;
    logic [NR-1:0] one;
    one = NR'(1) << who;
    done_delay = d; slave_rdata = sdata;
    @(posedge clk); #1;
    chk({nm, "_gnt"}, gnt, one);
    chk({nm, "_cmd"}, {m_wr, m_addr, m_wdata}, {p_wr[who], p_addr[who], p_wdata[who]});
    chk({nm, "_busy"}, busy, 1'b1);
    req_wr[who] = ~p_wr[who];
    req_addr[who*7 +: 7] = ~p_addr[who];
    req_wdata[who*8 +: 8] = ~p_wdata[who];
    t = 0; newd_n = 0; ab_n = 0; ab_first = -1; bad_gnt = 0; got = 0; rsp_t = -1;
    rv = '0; e = 1'b0; rd = 8'h00;
    while (!got && t < 400) begin
      if (m_newd) newd_n++;
      if (m_abort) begin
        if (ab_first < 0) ab_first = t;
        ab_n++;
      end
      if (gnt !== one) bad_gnt++;
      if (rsp_valid !== '0) begin
        got = 1; rsp_t = t; rv = rsp_valid; e = rsp_err; rd = rsp_rdata;
      end else begin
        @(posedge clk); #1;
        t++;
      end
    end
    chk({nm, "_rsp_seen"}, got, 1'b1);
    chk({nm, "_rsp_t"}, rsp_t, exp_t);
    chk({nm, "_rsp_valid"}, rv, one);
    chk({nm, "_rsp_err"}, e, exp_err);
    chk({nm, "_rsp_rdata"}, rd, exp_rdata);
    chk({nm, "_newd_len"}, newd_n, NH);
    chk({nm, "_abort_len"}, ab_n, exp_err ? AB : 0);
    if (exp_err) chk({nm, "_abort_start"}, ab_first, TO);
    chk({nm, "_gnt_steady"}, bad_gnt, 0);
    chk({nm, "_cmd_hold"}, {m_wr, m_addr, m_wdata}, {p_wr[who], p_addr[who], p_wdata[who]});
    req_wr[who] = p_wr[who];
    req_addr[who*7 +: 7] = p_addr[who];
    req_wdata[who*8 +: 8] = p_wdata[who];
    if (drop) req[who] = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_post_idle"}, {gnt, rsp_valid, busy}, '0);
  endtask

  initial begin
    bit [NR-1:0] pend;
    int last, w, d;
    bit err, wr;
    bit [7:0] rd, sd;
    int t;

    vt[0] = '{0, 1'b1, 7'h50, 8'hA5, 8'h77, 30,  1'b0, 8'h00, 31};
    vt[1] = '{2, 1'b0, 7'h1E, 8'h00, 8'h3C, 40,  1'b0, 8'h3C, 41};
    vt[2] = '{1, 1'b0, 7'h2A, 8'h11, 8'hC3, 5,   1'b0, 8'hC3, 25};
    vt[3] = '{3, 1'b0, 7'h7F, 8'hFF, 8'h99, -1,  1'b1, 8'h00, 132};
    vt[4] = '{0, 1'b0, 7'h01, 8'h00, 8'h5A, 99,  1'b0, 8'h5A, 100};
    vt[5] = '{1, 1'b0, 7'h02, 8'h00, 8'h6B, 100, 1'b1, 8'h00, 132};
    vt[6] = '{2, 1'b1, 7'h33, 8'h0F, 8'hEE, 23,  1'b0, 8'h00, 25};
    vt[7] = '{3, 1'b1, 7'h44, 8'h81, 8'h12, -1,  1'b1, 8'h00, 132};

    rst_n = 1'b0; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    done_delay = -1; slave_rdata = 8'h00;
    for (int i = 0; i < NR; i++) begin p_wr[i] = 0; p_addr[i] = 0; p_wdata[i] = 0; end
    repeat (3) @(posedge clk); #1;
    chk("reset_ctl", {gnt, rsp_valid, busy, m_newd, m_abort}, '0);
    chk("reset_data", {m_wr, m_addr, m_wdata, rsp_err, rsp_rdata}, '0);
    rst_n = 1'b1;

    // Single transfers from the vector table
    for (int i = 0; i < 8; i++) begin
      set_req(vt[i].who, vt[i].wr, vt[i].addr, vt[i].wdata);
      run_xfer(vt[i].who, vt[i].d, vt[i].sdata, vt[i].exp_err, vt[i].exp_rdata,
               vt[i].exp_t, 1'b1, $sformatf("vec%0d", i));
    end

    // Fairness: all four requesting continuously from reset
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, i[0], 7'(8'h10 + i), 8'(8'hB0 + i));
    for (int k = 0; k < 5; k++) begin
      d = 10 + 7 * k; sd = 8'(8'h60 + k);
      ref_outcome(d, p_wr[order[k]], sd, err, rd, t);
      run_xfer(order[k], d, sd, err, rd, t, 1'b0, $sformatf("fair%0d", k));
    end
    req = '0;

    // Reset while waiting on the master
    do_reset();
    set_req(1, 1'b0, 7'h11, 8'h00);
    done_delay = -1;
    @(posedge clk); #1;
    chk("mid_gnt", gnt, 4'b0010);
    repeat (40) @(posedge clk);
    #1;
    chk("mid_wait_state", {busy, m_newd, m_abort}, 3'b100);
    rst_n = 1'b0; req = '0;
    @(posedge clk); #1;
    chk("mid_rst_ctl", {gnt, rsp_valid, busy, m_newd, m_abort}, '0);
    chk("mid_rst_data", {m_wr, m_addr, m_wdata, rsp_err, rsp_rdata}, '0);
    rst_n = 1'b1;
    set_req(1, 1'b0, 7'h21, 8'h00);
    set_req(2, 1'b1, 7'h22, 8'h5C);
    ref_outcome(30, 1'b0, 8'h42, err, rd, t);
    run_xfer(1, 30, 8'h42, err, rd, t, 1'b1, "postrst");
    req = '0;

    // Randomized traffic against the round-robin reference model
    do_reset();
    pend = '0; last = NR - 1;
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < NR; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, 1'($urandom), 7'($urandom), 8'($urandom));
          pend[i] = 1'b1;
        end
      if (pend == '0) begin
        w = $urandom_range(0, NR - 1);
        set_req(w, 1'($urandom), 7'($urandom), 8'($urandom));
        pend[w] = 1'b1;
      end
      w = rr_next(pend, last);
      d = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(2, 110);
      sd = 8'($urandom);
      wr = p_wr[w];
      ref_outcome(d, wr, sd, err, rd, t);
      run_xfer(w, d, sd, err, rd, t, 1'b1, $sformatf("rnd%0d", it));
      pend[w] = 1'b0;
      last = w;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
